// File: rtl/phy_rx_pkg.sv
// Shared definitions for the 2-bit serial receiver: sync FSM encoding and defaults.
package phy_rx_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        ACTIVE  = 2'd2
    } rx_state_t;

    localparam logic [7:0] COMMA_DEFAULT      = 8'hBC;
    localparam int         LOCK_COUNT_DEFAULT = 4;

    // Word presented on paralelo for a given candidate: idle commas carry valid = 0.
    function automatic logic [8:0] rx_word(input logic [7:0] win, input logic [7:0] comma);
        rx_word = (win == comma) ? {1'b0, comma} : {1'b1, win};
    endfunction

endpackage

// File: rtl/phy_rx_sync_fsm.sv
// Word-alignment state machine: hunts for COMMA at any bit offset, confirms it on
// LOCK_COUNT consecutive word boundaries, then stays locked until reset.
import phy_rx_pkg::*;

module rx_sync_fsm #(
    parameter logic [7:0] COMMA      = COMMA_DEFAULT,
    parameter int         LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_win,
    output logic       o_lock,
    output logic       o_boundary
);

    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0] LC    = CW'(LOCK_COUNT);
    localparam logic [CW-1:0] LC_M1 = CW'(LOCK_COUNT - 1);

    rx_state_t     r_state;
    logic [1:0]    r_phase;
    logic [CW-1:0] r_bc_cnt;
    logic          r_lock;

    logic w_match;
    logic w_bnd;

    assign w_match    = (i_win == COMMA);
    assign w_bnd      = (r_phase == 2'd3);
    assign o_lock     = r_lock;
    assign o_boundary = w_bnd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= HUNT;
            r_phase  <= 2'd0;
            r_bc_cnt <= '0;
            r_lock   <= 1'b0;
        end else begin
            r_phase <= r_phase + 2'd1;
            case (r_state)
                HUNT: begin
                    // Realign: the comma just completed, so the next edge starts a fresh word.
                    if (w_match) begin
                        r_phase  <= 2'd0;
                        r_bc_cnt <= CW'(1);
                        r_state  <= LOCKING;
                    end
                end
                LOCKING: begin
                    if (w_bnd) begin
                        if (!w_match) begin
                            r_bc_cnt <= '0;
                            r_state  <= HUNT;
                        end else if (r_bc_cnt >= LC_M1) begin
                            r_bc_cnt <= LC;
                            r_state  <= ACTIVE;
                            r_lock   <= 1'b1;
                        end else begin
                            r_bc_cnt <= r_bc_cnt + CW'(1);
                        end
                    end
                end
                ACTIVE: begin
                    r_lock <= 1'b1;
                end
                default: begin
                    r_state  <= HUNT;
                    r_bc_cnt <= '0;
                    r_lock   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/phy_rx.sv
// Two-bits-per-cycle serial receiver: deserialises MSB first, aligns on COMMA and
// emits one 9-bit word (valid + data) every four cycles once locked.
import phy_rx_pkg::*;

module phy_rx #(
    parameter logic [7:0] COMMA      = COMMA_DEFAULT,
    parameter int         LOCK_COUNT = LOCK_COUNT_DEFAULT
) (
    input  logic       clk16f,
    input  logic       reset,
    input  logic [1:0] serial,
    output logic [8:0] paralelo,
    output logic       word_stb,
    output logic       active
);

    logic [5:0] r_sr;
    logic [8:0] r_paralelo;
    logic       r_word_stb;

    logic [7:0] w_win;
    logic       w_lock;
    logic       w_bnd;

    // Candidate includes the dibit being sampled this edge, so words land with no extra lag.
    assign w_win = {r_sr, serial};

    rx_sync_fsm #(
        .COMMA      (COMMA),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_sync (
        .clk        (clk16f),
        .rst        (reset),
        .i_win      (w_win),
        .o_lock     (w_lock),
        .o_boundary (w_bnd)
    );

    always_ff @(posedge clk16f or posedge reset) begin
        if (reset) begin
            r_sr       <= '0;
            r_paralelo <= '0;
            r_word_stb <= 1'b0;
        end else begin
            r_sr       <= {r_sr[3:0], serial};
            r_word_stb <= 1'b0;
            if (w_lock && w_bnd) begin
                r_paralelo <= rx_word(w_win, COMMA);
                r_word_stb <= 1'b1;
            end
        end
    end

    assign paralelo = r_paralelo;
    assign word_stb = r_word_stb;
    assign active   = w_lock;

endmodule

// File: tb/tb_phy_rx.sv
// Directed bench for phy_rx: lock/relock sequences, idle words and reset behaviour.
module tb_phy_rx;

    logic       clk16f;
    logic       reset;
    logic [1:0] serial;
    logic [8:0] paralelo;
    logic       word_stb;
    logic       active;

    int n_tests = 0;
    int n_fail  = 0;
    int stb_cnt = 0;

    phy_rx dut (
        .clk16f   (clk16f),
        .reset    (reset),
        .serial   (serial),
        .paralelo (paralelo),
        .word_stb (word_stb),
        .active   (active)
    );

    initial clk16f = 1'b0;
    always #5 clk16f = ~clk16f;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_dibit(input logic [1:0] d);
        @(negedge clk16f);
        serial = d;
        @(posedge clk16f);
        #1;
        if (word_stb) stb_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        stb_cnt = 0;
        send_dibit(b[7:6]);
        send_dibit(b[5:4]);
        send_dibit(b[3:2]);
        send_dibit(b[1:0]);
    endtask

    task automatic do_reset();
        @(negedge clk16f);
        reset  = 1'b1;
        serial = 2'b00;
        repeat (2) @(negedge clk16f);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        serial = 2'b00;
        repeat (3) @(negedge clk16f);
        chk("rst_paralelo", 32'(paralelo), 32'h000);
        chk("rst_stb", 32'(word_stb), 0);
        chk("rst_active", 32'(active), 0);
        reset = 1'b0;

        // Aligned lock then a data word
        repeat (3) send_byte(8'hBC);
        chk("al_active_3bc", 32'(active), 0);
        send_byte(8'hBC);
        chk("al_active_4bc", 32'(active), 1);
        chk("al_stb_lockword", 32'(stb_cnt), 0);
        chk("al_paralelo_lock", 32'(paralelo), 32'h000);
        send_byte(8'h5A);
        chk("al_paralelo_5a", 32'(paralelo), 32'h15A);
        chk("al_stb_5a", 32'(word_stb), 1);
        chk("al_stbcnt_5a", 32'(stb_cnt), 1);

        // Idle then data while locked
        send_byte(8'hBC);
        chk("idle_paralelo_bc", 32'(paralelo), 32'h0BC);
        chk("idle_stbcnt_bc", 32'(stb_cnt), 1);
        send_byte(8'hA5);
        chk("idle_paralelo_a5", 32'(paralelo), 32'h1A5);
        chk("idle_stbcnt_a5", 32'(stb_cnt), 1);
        send_dibit(2'b00);
        chk("hold_paralelo", 32'(paralelo), 32'h1A5);
        chk("hold_stb", 32'(word_stb), 0);

        // Mid-word reset while active; a comma straddling release must not match
        send_dibit(2'b11);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_paralelo", 32'(paralelo), 32'h000);
        chk("mid_rst_active", 32'(active), 0);
        chk("mid_rst_stb", 32'(word_stb), 0);
        send_dibit(2'b10);
        send_dibit(2'b11);
        @(negedge clk16f);
        reset  = 1'b0;
        serial = 2'b11;
        @(posedge clk16f);
        #1;
        send_dibit(2'b00);
        chk("straddle_active", 32'(active), 0);
        repeat (3) send_byte(8'hBC);
        chk("relock_active_3bc", 32'(active), 0);
        send_byte(8'hBC);
        chk("relock_active_4bc", 32'(active), 1);
        send_byte(8'h12);
        chk("relock_paralelo", 32'(paralelo), 32'h112);

        // Misaligned lock: one-dibit prefix
        do_reset();
        send_dibit(2'b01);
        repeat (4) send_byte(8'hBC);
        chk("mis_active", 32'(active), 1);
        send_byte(8'hFF);
        chk("mis_paralelo", 32'(paralelo), 32'h1FF);
        chk("mis_stbcnt", 32'(stb_cnt), 1);

        // Broken lock sequence then recovery
        do_reset();
        repeat (3) send_byte(8'hBC);
        send_byte(8'h00);
        chk("brk_active_00", 32'(active), 0);
        repeat (3) send_byte(8'hBC);
        chk("brk_active_3bc", 32'(active), 0);
        send_byte(8'hBC);
        chk("brk_active_4bc", 32'(active), 1);
        send_byte(8'h33);
        chk("brk_paralelo", 32'(paralelo), 32'h133);

        // Partial lock sequence never locks
        do_reset();
        repeat (3) send_byte(8'hBC);
        stb_cnt = 0;
        begin
            int tot;
            tot = 0;
            for (int i = 0; i < 4; i++) begin
                send_byte(8'h00);
                tot += stb_cnt;
            end
            chk("part_active", 32'(active), 0);
            chk("part_stb", 32'(tot), 0);
            chk("part_paralelo", 32'(paralelo), 32'h000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phy_rx.md
PHY_RX -- requirements
Module: phy_rx

Interface
REQ-001 Parameter COMMA, default 8'hBC: alignment/idle symbol.
REQ-002 Parameter LOCK_COUNT, default 4: number of consecutive aligned COMMA words needed to lock.
REQ-003 clk16f  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 serial  input  [1:0]  two serial bits per cycle; serial[1] is the earlier (more significant) bit.
REQ-006 paralelo  output  [8:0]  recovered word; bit 8 = valid, bits 7:0 = data.
REQ-007 word_stb  output  1  one-cycle pulse marking a new paralelo value.
REQ-008 active  output  1  high while the receiver is locked (state ACTIVE).

Function
REQ-009 A 6-bit shift register sr SHALL update every cycle: sr <= {sr[3:0], serial}.
REQ-010 The candidate word SHALL be win = {sr[5:0], serial}, which is the latest 8 bits, MSB first.
REQ-011 FSM states SHALL be HUNT, LOCKING and ACTIVE.
REQ-012 A 2-bit phase counter SHALL increment every cycle with wrap 3->0; a word boundary occurs when the counter value is 3.
REQ-013 HUNT: the FSM SHALL compare win with COMMA every cycle, at all four bit alignments.
REQ-014 On a HUNT match, the FSM SHALL set the phase counter to 0, set bc_count to 1 and go to LOCKING.
REQ-015 LOCKING: the FSM SHALL compare only at word boundaries.
REQ-016 A LOCKING match SHALL increment bc_count; on reaching LOCK_COUNT the FSM goes to ACTIVE.
REQ-017 A LOCKING mismatch SHALL return the FSM to HUNT with bc_count = 0.
REQ-018 Non-boundary cycles in LOCKING SHALL change nothing except sr and the phase counter.
REQ-019 The COMMA word that completes lock SHALL NOT be output; word_stb stays 0 for it.
REQ-020 ACTIVE word boundary with win == COMMA: paralelo SHALL become 9'h0BC (valid = 0) and word_stb SHALL be 1.
REQ-021 ACTIVE word boundary with win != COMMA: paralelo SHALL become {1'b1, win} and word_stb SHALL be 1.
REQ-022 ACTIVE non-boundary cycles: paralelo SHALL hold and word_stb SHALL be 0.
REQ-023 Latency: paralelo/word_stb SHALL update on the same rising edge that samples the last 2 bits of the word (one edge after those bits are presented).
REQ-024 ACTIVE SHALL be sticky; it is left only via reset.
REQ-025 In HUNT and LOCKING: paralelo = 9'h000, word_stb = 0, active = 0.
REQ-026 active SHALL be registered and assert on the edge that enters ACTIVE.
REQ-027 bc_count SHALL saturate at LOCK_COUNT and never wrap.

Reset
REQ-028 While reset = 1, asynchronously: state = HUNT, sr = 0, phase = 0, bc_count = 0, paralelo = 9'h000, word_stb = 0, active = 0.
REQ-029 Reset asserted mid-word or while ACTIVE SHALL discard partial data; after deassertion, hunting restarts from HUNT.
REQ-030 A COMMA pattern straddling reset deassertion SHALL NOT match, because sr is cleared.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, COMMA default (8'hBC) and LOCK_COUNT default (4).
REQ-032 A single sub-module, rx_sync_fsm, SHALL hold the state, phase counter and bc_count, and output lock/boundary indications.
REQ-033 The top level SHALL hold sr and the output registers.

Verification
REQ-034 Lock, aligned: reset, then 4x 8'hBC MSB-first aligned to a phase boundary, then 8'h5A -> active rises on the 4th BC's last edge; paralelo = 9'h15A, word_stb = 1 exactly one cycle, 4 cycles later.
REQ-035 Lock, misaligned: prefix of 1 dibit (2'b01), then 4x BC, then 8'hFF -> lock achieved; paralelo = 9'h1FF.
REQ-036 Broken lock sequence: 3x BC, 8'h00, 4x BC, 8'h33 -> back to HUNT after 8'h00 (active stays 0); later locks; paralelo = 9'h133.
REQ-037 Idle while ACTIVE: BC, then 8'hA5 -> paralelo = 9'h0BC then 9'h1A5; word_stb pulses every 4 cycles.
REQ-038 Mid-operation reset: assert reset while ACTIVE and 2 dibits into a word -> all outputs 0 immediately; relock requires 4 new BC.
REQ-039 Partial lock sequence: 3x BC only, then idle 0s -> active never asserts and word_stb stays 0.
